// File: rtl/ps2_keypad.sv
// ps2_keypad: PS/2 keyboard receiver that decodes make/break codes into a 10-key gamepad bitmap.
// Receive only; ps2_clk/ps2_data are sampled through synchronizers and never driven.
module ps2_keypad #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] keys,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          brk_q, brk_d, ext_q, ext_d;
    logic [9:0]    keys_q, keys_d;
    logic [7:0]    scan_code_q;
    logic          scan_valid_q, frame_err_q;
    logic          fall, din, good, bad;
    logic [3:0]    idx;

    // clk_sync_q: [0] first stage, [1] synced level, [2] previous synced level
    assign fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign din  = dat_sync_q[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        par_ok_d = par_ok_q;
        tmo_d    = (state_q == IDLE) ? '0 : tmo_q + 1'b1;
        good     = 1'b0;
        bad      = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    state_d = din ? IDLE : DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    shift_d = {din, shift_q[7:1]};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_ok_d = ^{shift_q, din};
                    state_d  = STOP;
                end
                default: begin
                    good    = din & par_ok_q;
                    bad     = ~good;
                    state_d = IDLE;
                end
            endcase
        end else if (state_q != IDLE && tmo_q == TMAX) begin
            state_d = IDLE;
            tmo_d   = '0;
            bad     = 1'b1;
        end
    end

    // Keys are decoded from the byte as it is accepted, so they move in step with scan_valid.
    assign idx = !ext_q ? (shift_q == 8'h1C ? 4'd9 :
                           shift_q == 8'h1B ? 4'd8 :
                           shift_q == 8'h22 ? 4'd0 :
                           shift_q == 8'h1A ? 4'd1 :
                           shift_q == 8'h66 ? 4'd2 :
                           shift_q == 8'h5A ? 4'd3 : 4'd15)
                        : (shift_q == 8'h74 ? 4'd4 :
                           shift_q == 8'h6B ? 4'd5 :
                           shift_q == 8'h75 ? 4'd6 :
                           shift_q == 8'h72 ? 4'd7 : 4'd15);

    always_comb begin
        keys_d = keys_q;
        brk_d  = brk_q;
        ext_d  = ext_q;
        if (bad) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (good) begin
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (idx < 4'd10) keys_d[idx] = ~brk_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            tmo_q        <= '0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            keys_q       <= '0;
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q   <= {dat_sync_q[0], ps2_data};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            tmo_q        <= tmo_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            keys_q       <= keys_d;
            scan_code_q  <= good ? shift_q : scan_code_q;
            scan_valid_q <= good;
            frame_err_q  <= bad;
        end
    end

    assign keys       = keys_q;
    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;
endmodule
